// File: rtl/shift_pipe_arbiter.sv
// shift_pipe_arbiter: round-robin A/B scheduler feeding a DEPTH-stage valid/tagged shift pipe with a valid/ready output.
// Optional per-stage parity and the out_parity port are enabled with SHIFT_PIPE_PARITY_EN.
module shift_pipe_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int OCC_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             grant_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             grant_b,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy,
`ifdef SHIFT_PIPE_PARITY_EN
  output logic             out_parity,
`endif
  output logic [OCC_W-1:0] occupancy
);
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] tag_q;
  logic             ptr_q;
  logic             shift;
  logic             en;
  logic [WIDTH-1:0] win_data;
`ifdef SHIFT_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
`endif
  // advance unless the last stage holds a word the consumer refuses; grants only when the pipe moves, never in reset or flush
  always_comb begin
    shift    = !v_q[DEPTH-1] || out_ready;
    en       = shift && !flush && reset_n;
    grant_a  = en && req_a && (!req_b || !ptr_q);
    grant_b  = en && req_b && (!req_a || ptr_q);
    win_data = grant_b ? data_b : data_a;
  end
  // stage registers, tags, valid bits and the round-robin pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      v_q   <= '0;
      tag_q <= '0;
      ptr_q <= 1'b0;
`ifdef SHIFT_PIPE_PARITY_EN
      par_q <= '0;
`endif
    end else if (flush) begin
      v_q <= '0;
`ifdef SHIFT_PIPE_PARITY_EN
      par_q <= '0;
`endif
    end else if (shift) begin
      for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
      data_q[0] <= (grant_a || grant_b) ? win_data : data_q[0];
      v_q       <= {v_q[DEPTH-2:0], grant_a || grant_b};
      tag_q     <= {tag_q[DEPTH-2:0], (grant_a || grant_b) ? grant_b : tag_q[0]};
      ptr_q     <= (grant_a || grant_b) ? grant_a : ptr_q;
`ifdef SHIFT_PIPE_PARITY_EN
      par_q     <= {par_q[DEPTH-2:0], (grant_a || grant_b) ? ^win_data : par_q[0]};
`endif
    end
  end
  // occupancy is a popcount of the registered valid bits
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(v_q[i]);
  end
  assign busy      = |v_q;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_src   = tag_q[DEPTH-1];
`ifdef SHIFT_PIPE_PARITY_EN
  assign out_parity = par_q[DEPTH-1];
`endif
endmodule

// File: tb/tb_shift_pipe_arbiter.sv
// tb_shift_pipe_arbiter: directed and random checks of shift_pipe_arbiter against a slot model and an order scoreboard.
module tb_shift_pipe_arbiter;
  localparam int W = 4;
  localparam int D = 4;
  logic clock = 0, reset_n = 0;
  logic req_a = 0, req_b = 0, flush = 0, out_ready = 0;
  logic [W-1:0] data_a = 0, data_b = 0;
  logic grant_a, grant_b, out_valid, out_src, busy;
  logic [W-1:0] out_data;
  logic [2:0] occupancy;
`ifdef SHIFT_PIPE_PARITY_EN
  logic out_parity;
`endif
  int total = 0, bad = 0;
  bit m_v [D];
  bit [W-1:0] m_d [D];
  bit m_s [D];
  bit m_ptr;
  logic [W:0] sq [$];
  bit last_ga, last_gb;

  shift_pipe_arbiter #(.WIDTH(W), .DEPTH(D), .OCC_W(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_a(req_a), .data_a(data_a), .grant_a(grant_a),
    .req_b(req_b), .data_b(data_b), .grant_b(grant_b),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy),
`ifdef SHIFT_PIPE_PARITY_EN
    .out_parity(out_parity),
`endif
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < D; i++) begin m_v[i] = 0; m_d[i] = 0; m_s[i] = 0; end
    m_ptr = 0;
    sq.delete();
  endtask

  // one clock cycle: drive, check against the model away from the edge, then advance the model at the edge
  task automatic step(input bit ra, input bit [W-1:0] da, input bit rb, input bit [W-1:0] db,
                      input bit rdy, input bit fl);
    bit moving, win_b, ega, egb;
    int occ;
    logic [W:0] head;
    @(negedge clock);
    req_a = ra; data_a = da; req_b = rb; data_b = db; out_ready = rdy; flush = fl;
    #1;
    moving = (m_v[D-1] == 0) || rdy;
    win_b = (ra && rb) ? m_ptr : rb;
    ega = moving && !fl && (ra || rb) && !win_b;
    egb = moving && !fl && (ra || rb) && win_b;
    occ = 0;
    for (int i = 0; i < D; i++) occ += m_v[i];
    chk("grant_a", grant_a, ega);
    chk("grant_b", grant_b, egb);
    chk("out_valid", out_valid, m_v[D-1]);
    chk("occupancy", occupancy, occ[7:0]);
    chk("busy", busy, occ != 0);
    if (m_v[D-1]) begin
      chk("out_data", out_data, m_d[D-1]);
      chk("out_src", out_src, m_s[D-1]);
    end
    if (out_valid === 1'b1 && rdy) begin
      head = (sq.size() > 0) ? sq.pop_front() : 5'h1f;
      chk("order", {out_src, out_data}, head);
    end
    if (ega) sq.push_back({1'b0, da});
    if (egb) sq.push_back({1'b1, db});
    @(posedge clock);
    if (fl) begin
      for (int i = 0; i < D; i++) m_v[i] = 0;
      sq.delete();
    end else if (moving) begin
      for (int i = D - 1; i > 0; i--) begin m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; m_s[i] = m_s[i-1]; end
      m_v[0] = ega || egb;
      if (ega) begin m_d[0] = da; m_s[0] = 0; m_ptr = 1; end
      if (egb) begin m_d[0] = db; m_s[0] = 1; m_ptr = 0; end
    end
    last_ga = ega; last_gb = egb;
  endtask

  initial begin
    bit ra, rb, rdy, fl;
    bit [W-1:0] da, db;
    m_reset();
    req_a = 1; req_b = 1;
    #12;
    chk("rst_grant_a", grant_a, 0);
    chk("rst_grant_b", grant_b, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_occupancy", occupancy, 0);
    @(negedge clock); reset_n = 1; req_a = 0; req_b = 0;
    // single word, 4-cycle latency
    step(1, 4'b1010, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("single_out_data", out_data, 4'b1010);
    step(0, 0, 0, 0, 1, 0);
    // contention alternates starting from the pointer
    for (int i = 0; i < 4; i++) step(1, 4'b0001, 1, 4'b0010, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    // backpressure freezes the full pipe
    for (int i = 0; i < 4; i++) step(1, 4'(i + 3), 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 4'hf, 1, 4'he, 0, 0);
    chk("bp_occupancy", occupancy, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    // bubbles
    step(1, 4'h5, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 4'h6, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
    // flush with three valid stages and a waiting requester
    for (int i = 0; i < 3; i++) step(1, 4'(i + 8), 0, 0, 1, 0);
    step(0, 0, 1, 4'h7, 1, 1);
    chk("flush_grant_b", grant_b, 0);
    step(0, 0, 1, 4'h7, 1, 0);
    chk("post_flush_grant_b", grant_b, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    // asynchronous reset with words in flight, pointer left at B
    step(1, 4'h3, 0, 0, 1, 0);
    step(1, 4'h4, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    @(negedge clock); #2 reset_n = 0; #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_occupancy", occupancy, 0);
    chk("async_grant_a", grant_a, 0);
    m_reset();
    @(negedge clock); reset_n = 1;
    step(1, 4'h9, 1, 4'hc, 1, 0);
    chk("rst_ptr_grant_a", last_ga, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    // random traffic with requests held until granted
    ra = 0; rb = 0; da = 0; db = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ra || last_ga) begin ra = 1'($urandom_range(0, 1)); da = 4'($urandom); end
      if (!rb || last_gb) begin rb = 1'($urandom_range(0, 1)); db = 4'($urandom); end
      rdy = $urandom_range(0, 9) < 7;
      fl = $urandom_range(0, 19) == 0;
      last_ga = 0; last_gb = 0;
      step(ra, da, rb, db, rdy, fl);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
